// File: rtl/contador_4bit_desc_lim12_pkg.sv
// Shared definitions for the descending LIMIT..0 counter: state encoding and defaults.
package contador_4bit_desc_lim12_pkg;

  localparam int          WIDTH_4  = 4;
  localparam logic [3:0]  LIMIT_12 = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/contador_4bit_desc_lim12.sv
// Descending modulo counter LIMIT..0 with free-run wrap (borrow pulse) or one-shot stop.
module contador_4bit_desc_lim12
  import contador_4bit_desc_lim12_pkg::*;
#(
  parameter int WIDTH = WIDTH_4,
  parameter int LIMIT = int'(LIMIT_12)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             borrow_next;

  // Priority load > start > en; the zero case is decoded before decrementing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next  = state;
    count_next  = count;
    borrow_next = 1'b0;
    if (load) begin
      count_next = (load_val > LIM) ? LIM : load_val;
      state_next = ST_IDLE;
    end else if (start && state != ST_RUN) begin
      state_next = ST_RUN;
    end else if (state == ST_RUN && en) begin
      if (count == '0) begin
        if (one_shot) begin
          state_next = ST_DONE;
        end else begin
          count_next  = LIM;
          borrow_next = 1'b1;
        end
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  // busy/done are flopped from the next state so every output comes straight off a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= LIM;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state  <= state_next;
      count  <= count_next;
      borrow <= borrow_next;
      busy   <= (state_next == ST_RUN);
      done   <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_contador_4bit_desc_lim12.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_contador_4bit_desc_lim12;

  localparam int LIMIT = 12;

  logic       clk;
  logic       reset;
  logic       en, start, load, one_shot;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       borrow, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  contador_4bit_desc_lim12 dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .one_shot (one_shot),
    .count    (count),
    .borrow   (borrow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers and flags describing what the counter must show.
  int m_count;
  bit m_running, m_finished, m_borrow;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count = LIMIT; m_running = 0; m_finished = 0; m_borrow = 0;
    end else begin
      m_borrow = 0;
      if (load) begin
        m_count    = (int'(load_val) < LIMIT) ? int'(load_val) : LIMIT;
        m_running  = 0;
        m_finished = 0;
      end else if (start && !m_running) begin
        m_running  = 1;
        m_finished = 0;
      end else if (m_running && en) begin
        if (m_count > 0)      m_count = m_count - 1;
        else if (one_shot)    begin m_running = 0; m_finished = 1; end
        else                  begin m_count = LIMIT; m_borrow = 1; end
      end
    end
  end

  always @(negedge clk) begin
    check("count", int'(count), m_count);
    check("borrow", int'(borrow), int'(m_borrow));
    check("busy", int'(busy), int'(m_running));
    check("done", int'(done), int'(m_finished));
  end

  task automatic drive(input bit l, input int lv, input bit s, input bit e, input bit os);
    load = l; load_val = 4'(lv); start = s; en = e; one_shot = os;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int borrows;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Reset then free-run
    step(3);
    check("reset_count", int'(count), 12);
    check("reset_busy", int'(busy), 0);
    check("model_pin_reset", m_count, 12);
    reset = 1'b1;
    drive(0, 0, 1, 1, 0);
    step();
    check("start_busy", int'(busy), 1);
    check("start_count", int'(count), 12);
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check("free_seq", int'(count), 12 - i);
    end
    step();
    check("wrap_count", int'(count), 12);
    check("wrap_borrow", int'(borrow), 1);
    check("model_pin_wrap", int'(m_borrow), 1);
    borrows = 0;
    for (int i = 0; i < 26; i++) begin
      step();
      if (borrow) borrows++;
    end
    check("borrow_per_period", borrows, 2);
    check("period_count", int'(count), 12);

    // One-shot stop
    drive(1, 3, 0, 0, 1);
    step();
    check("load3_count", int'(count), 3);
    check("load3_busy", int'(busy), 0);
    drive(0, 0, 1, 0, 1);
    step();
    check("os_busy", int'(busy), 1);
    drive(0, 0, 0, 1, 1);
    step(3);
    check("os_zero", int'(count), 0);
    check("os_still_busy", int'(busy), 1);
    step();
    check("os_done", int'(done), 1);
    check("os_busy_off", int'(busy), 0);
    step(2);
    check("os_hold", int'(count), 0);
    check("os_no_borrow", int'(borrow), 0);

    // Load clamp and priority
    drive(1, 15, 1, 1, 0);
    step();
    check("clamp_count", int'(count), 12);
    check("clamp_busy", int'(busy), 0);
    check("clamp_done", int'(done), 0);
    drive(0, 0, 1, 0, 0);
    step();
    check("prio_busy", int'(busy), 1);
    check("prio_count", int'(count), 12);

    // Enable gating
    drive(0, 0, 0, 1, 0);
    step(5);
    check("gate_at7", int'(count), 7);
    drive(0, 0, 0, 0, 0);
    step(4);
    check("gate_hold", int'(count), 7);
    drive(0, 0, 0, 1, 0);
    step();
    check("gate_resume6", int'(count), 6);
    step();
    check("gate_resume5", int'(count), 5);
    drive(1, 9, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 0);
    step(5);
    check("idle_hold", int'(count), 9);

    // Async reset mid-operation with a wrap due
    drive(1, 2, 0, 0, 0);
    step();
    drive(0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 1, 0);
    step(2);
    check("pre_reset_zero", int'(count), 0);
    reset = 1'b0;
    #1;
    check("async_count", int'(count), 12);
    check("async_borrow", int'(borrow), 0);
    check("async_busy", int'(busy), 0);
    step(2);
    reset = 1'b1;
    step(3);
    check("post_reset_borrow", int'(borrow), 0);
    check("post_reset_count", int'(count), 12);

    // Restart from DONE
    drive(1, 1, 0, 0, 1);
    step();
    drive(0, 0, 1, 0, 1);
    step();
    drive(0, 0, 0, 1, 1);
    step(2);
    check("restart_in_done", int'(done), 1);
    drive(0, 0, 1, 1, 0);
    step();
    check("restart_busy", int'(busy), 1);
    check("restart_done", int'(done), 0);
    check("restart_count", int'(count), 0);
    drive(0, 0, 0, 1, 0);
    step();
    check("restart_wrap", int'(count), 12);
    check("restart_borrow", int'(borrow), 1);
    step();
    check("restart_borrow_off", int'(borrow), 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
